cdcm_rx_align_ctrl: RTL and testbench

Sequencer for one CDCM-8 receive lane (IBUFDS → IDELAYE3/ODELAYE3 cascade → ISERDESE3 → bitslip mux). After IDELAY init completes, it scans all 32 coarse taps and records which taps give a stable deserialized word. It then loads the centre of the widest passing window and issues bitslips until the word equals the idle pattern. It drives the lane's tap/load/VTC/bitslip inputs and reports aligned/error status to the link layer.

---
 rtl/cdcm_rx_align_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_cdcm_rx_align_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdcm_rx_align_ctrl.sv
// -----------------------------------------------------------------------------
// cdcm_rx_align_ctrl
//   Alignment sequencer for one CDCM-8 receive lane. After the lane's IDELAY
//   init completes it loads all 2**kTapW coarse taps in turn and checks each
//   one for a stable deserialized word. While scanning it tracks the widest
//   run of passing taps. It then loads the centre of that run and issues
//   bitslips until the word equals kIdlePattern. The result is reported on
//   aligned/error.
//
// Ports
//   clkDivIn        lane slow clock; all logic on its rising edge
//   pwrOnRst        synchronous active-high reset
//   start           one-cycle (re)align request, honoured only while busy=0
//   idelayInitDone  lane IDELAY init complete
//   dInFromDevice   deserialized word from the lane
//   tapOut          tap value to the lane (valid whenever tapLoad=1)
//   tapLoad         one-cycle tap load strobe
//   enVtc           VTC enable to the lane (released while a sequence runs)
//   bitslip         one-cycle bitslip pulse
//   busy            sequence in progress
//   aligned         lane aligned (held until the next start or reset)
//   error           alignment failed (held until the next start or reset)
//   eyeCenter       selected tap
//   eyeWidth        widest passing run length (0..2**kTapW)
//   o_dbg_state     current sequencer state, for observation only
//
// Handshake: start is a request without acknowledge. It is accepted only in
// IDLE. busy rises on the edge that accepts it and falls on the same edge that
// sets aligned or error. A start seen while busy=1 is dropped.
// -----------------------------------------------------------------------------
module cdcm_rx_align_ctrl #(
   parameter int               kDevW         = 8,
   parameter int               kTapW         = 5,
   parameter int               kSettleCycles = 16,
   parameter int               kCheckCycles  = 256,
   parameter int               kMinEyeWidth  = 4,
   parameter logic [kDevW-1:0] kIdlePattern  = 8'hF0,
   parameter int               kMaxSlip      = 8
) (
   input  logic             clkDivIn,
   input  logic             pwrOnRst,
   input  logic             start,
   input  logic             idelayInitDone,
   input  logic [kDevW-1:0] dInFromDevice,
   output logic [kTapW-1:0] tapOut,
   output logic             tapLoad,
   output logic             enVtc,
   output logic             bitslip,
   output logic             busy,
   output logic             aligned,
   output logic             error,
   output logic [kTapW-1:0] eyeCenter,
   output logic [kTapW:0]   eyeWidth,
   output logic [3:0]       o_dbg_state
);

   localparam logic [3:0] IDLE       = 4'd0;
   localparam logic [3:0] WAIT_INIT  = 4'd1;
   localparam logic [3:0] LOAD       = 4'd2;
   localparam logic [3:0] SETTLE     = 4'd3;
   localparam logic [3:0] CHECK      = 4'd4;
   localparam logic [3:0] CALC       = 4'd5;
   localparam logic [3:0] LOAD_C     = 4'd6;
   localparam logic [3:0] SETTLE_C   = 4'd7;
   localparam logic [3:0] SLIP_CHECK = 4'd8;
   localparam logic [3:0] SLIP       = 4'd9;
   localparam logic [3:0] SLIP_WAIT  = 4'd10;
   localparam logic [3:0] DONE       = 4'd11;
   localparam logic [3:0] ERROR      = 4'd12;

   localparam int kCntMax = (kCheckCycles > kSettleCycles) ? kCheckCycles : kSettleCycles;
   localparam int kCntW   = $clog2(kCntMax + 1);
   localparam int kSlipW  = $clog2(kMaxSlip + 1);

   localparam logic [kCntW-1:0]  kCntOne     = kCntW'(1);
   localparam logic [kCntW-1:0]  kSettleLast = kCntW'(kSettleCycles - 1);
   localparam logic [kCntW-1:0]  kCheckLast  = kCntW'(kCheckCycles);
   localparam logic [kSlipW-1:0] kSlipMax    = kSlipW'(kMaxSlip);
   localparam logic [kTapW:0]    kMinEye     = (kTapW + 1)'(kMinEyeWidth);
   localparam logic [kTapW-1:0]  kLastTap    = '1;

   logic [3:0]       r_state;
   logic [kCntW-1:0] r_cnt;
   logic [kTapW-1:0] r_tap;
   logic [kDevW-1:0] r_din;
   logic [kDevW-1:0] r_ref;
   logic             r_ok;
   logic [kTapW:0]   r_cur_len;
   logic [kTapW-1:0] r_cur_start;
   logic [kTapW:0]   r_best_len;
   logic [kTapW-1:0] r_best_start;
   logic [kSlipW-1:0] r_slip_cnt;
   logic             r_en_vtc;
   logic             r_busy;
   logic             r_aligned;
   logic             r_error;
   logic [kTapW-1:0] r_eye_center;
   logic [kTapW:0]   r_eye_width;

   logic             w_word_match;
   logic             w_idle_match;
   logic             w_check_pass;
   logic             w_idle_pass;
   logic [kTapW:0]   w_new_len;
   logic [kTapW-1:0] w_new_start;
   logic [kTapW-1:0] w_center;

   // Check windows: count 0 only lets the input register fill. In CHECK,
   // count 1 captures the reference word. Counts 2..kCheckCycles compare.
   // The last compare is folded into the pass result combinationally.
   assign w_word_match = (r_din == r_ref);
   assign w_idle_match = (r_din == kIdlePattern);
   assign w_check_pass = r_ok & w_word_match;
   assign w_idle_pass  = r_ok & w_idle_match;

   // The run can only grow on a pass. A run starting at this tap begins when
   // the current length is zero.
   assign w_new_len   = w_check_pass ? (r_cur_len + 1'b1) : '0;
   assign w_new_start = (r_cur_len == '0) ? r_tap : r_cur_start;
   // A run never wraps, so start + len/2 always stays inside the tap range.
   assign w_center    = r_best_start + r_best_len[kTapW:1];

   always_ff @(posedge clkDivIn) begin
      r_din <= dInFromDevice;
      if (pwrOnRst) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_tap        <= '0;
         r_ref        <= '0;
         r_ok         <= 1'b0;
         r_cur_len    <= '0;
         r_cur_start  <= '0;
         r_best_len   <= '0;
         r_best_start <= '0;
         r_slip_cnt   <= '0;
         r_en_vtc     <= 1'b1;
         r_busy       <= 1'b0;
         r_aligned    <= 1'b0;
         r_error      <= 1'b0;
         r_eye_center <= '0;
         r_eye_width  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state      <= WAIT_INIT;
                  r_busy       <= 1'b1;
                  r_aligned    <= 1'b0;
                  r_error      <= 1'b0;
                  r_en_vtc     <= 1'b0;
                  r_tap        <= '0;
                  r_cur_len    <= '0;
                  r_cur_start  <= '0;
                  r_best_len   <= '0;
                  r_best_start <= '0;
                  r_slip_cnt   <= '0;
                  r_cnt        <= '0;
               end
            end
            WAIT_INIT: begin
               if (idelayInitDone) r_state <= LOAD;
            end
            LOAD: begin
               r_state <= SETTLE;
               r_cnt   <= '0;
            end
            SETTLE, SETTLE_C, SLIP_WAIT: begin
               if (r_cnt == kSettleLast) begin
                  r_cnt   <= '0;
                  r_ok    <= 1'b1;
                  r_state <= (r_state == SETTLE) ? CHECK : SLIP_CHECK;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            CHECK: begin
               if (r_cnt == '0) begin
                  r_cnt <= r_cnt + 1'b1;
               end else if (r_cnt == kCntOne) begin
                  r_ref <= r_din;
                  r_cnt <= r_cnt + 1'b1;
               end else if (r_cnt != kCheckLast) begin
                  r_ok  <= r_ok & w_word_match;
                  r_cnt <= r_cnt + 1'b1;
               end else begin
                  r_cnt     <= '0;
                  r_cur_len <= w_new_len;
                  if (w_check_pass && (r_cur_len == '0)) r_cur_start <= r_tap;
                  // Strictly greater: on equal widths the earlier run is kept.
                  if (w_new_len > r_best_len) begin
                     r_best_len   <= w_new_len;
                     r_best_start <= w_new_start;
                  end
                  if (r_tap == kLastTap) begin
                     r_state <= CALC;
                  end else begin
                     r_tap   <= r_tap + 1'b1;
                     r_state <= LOAD;
                  end
               end
            end
            CALC: begin
               r_eye_width  <= r_best_len;
               r_eye_center <= w_center;
               if (r_best_len < kMinEye) begin
                  r_state <= ERROR;
               end else begin
                  r_tap   <= w_center;
                  r_state <= LOAD_C;
               end
            end
            LOAD_C: begin
               r_state <= SETTLE_C;
               r_cnt   <= '0;
            end
            SLIP_CHECK: begin
               if (r_cnt == '0) begin
                  r_cnt <= r_cnt + 1'b1;
               end else if (r_cnt != kCheckLast) begin
                  r_ok  <= r_ok & w_idle_match;
                  r_cnt <= r_cnt + 1'b1;
               end else begin
                  r_cnt <= '0;
                  if (w_idle_pass)                 r_state <= DONE;
                  else if (r_slip_cnt == kSlipMax) r_state <= ERROR;
                  else                             r_state <= SLIP;
               end
            end
            SLIP: begin
               r_slip_cnt <= r_slip_cnt + 1'b1;
               r_cnt      <= '0;
               r_state    <= SLIP_WAIT;
            end
            DONE: begin
               r_aligned <= 1'b1;
               r_en_vtc  <= 1'b1;
               r_busy    <= 1'b0;
               r_state   <= IDLE;
            end
            ERROR: begin
               r_error  <= 1'b1;
               r_en_vtc <= 1'b1;
               r_busy   <= 1'b0;
               r_state  <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // The strobes are decoded from state. Each strobe lasts exactly the one
   // cycle spent in its state, and the tap register is already valid then.
   assign tapLoad     = (r_state == LOAD) || (r_state == LOAD_C);
   assign bitslip     = (r_state == SLIP);
   assign tapOut      = r_tap;
   assign enVtc       = r_en_vtc;
   assign busy        = r_busy;
   assign aligned     = r_aligned;
   assign error       = r_error;
   assign eyeCenter   = r_eye_center;
   assign eyeWidth    = r_eye_width;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cdcm_rx_align_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cdcm_rx_align_ctrl
//   Bench for cdcm_rx_align_ctrl. A behavioural lane model drives the
//   deserialized word:
//     - a tap in pass_mask gives a stable word. That word becomes the idle
//       pattern once need_slips bitslips have been applied.
//     - any other tap gives a word that toggles on every cycle.
//   Each run pushes its expected outcome on exp_q when start is driven. The
//   outcome is computed from the mask by an independent run-length model.
//   The entry is popped and compared when busy falls.
// -----------------------------------------------------------------------------
module tb_cdcm_rx_align_ctrl;

   localparam int kSettle  = 4;
   localparam int kCheck   = 16;
   localparam int kMinEye  = 4;
   localparam int kMaxSlip = 8;
   localparam int kExpW    = 29;
   localparam int kBudget  = 6000;

   // clock / reset
   logic       clk;
   logic       rst;
   logic       start;
   logic       init_done;
   logic [7:0] din;
   logic [4:0] tapOut;
   logic       tapLoad;
   logic       enVtc;
   logic       bitslip;
   logic       busy;
   logic       aligned;
   logic       error;
   logic [4:0] eyeCenter;
   logic [5:0] eyeWidth;
   logic [3:0] dbg_state;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   cdcm_rx_align_ctrl #(
      .kDevW(8), .kTapW(5), .kSettleCycles(kSettle), .kCheckCycles(kCheck),
      .kMinEyeWidth(kMinEye), .kIdlePattern(8'hF0), .kMaxSlip(kMaxSlip)
   ) dut (
      .clkDivIn(clk), .pwrOnRst(rst), .start(start), .idelayInitDone(init_done),
      .dInFromDevice(din), .tapOut(tapOut), .tapLoad(tapLoad), .enVtc(enVtc),
      .bitslip(bitslip), .busy(busy), .aligned(aligned), .error(error),
      .eyeCenter(eyeCenter), .eyeWidth(eyeWidth), .o_dbg_state(dbg_state)
   );

   // scoreboard state
   logic [kExpW-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   // lane model state
   logic [31:0] pass_mask  = '0;
   int          need_slips = 0;
   logic [4:0]  lane_tap   = '0;
   int          lane_slips = 0;
   logic        toggle     = 1'b0;
   int          n_loads    = 0;
   int          n_slips    = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Lane model: reacts to the strobes and drives a new word at each negedge.
   initial begin
      din = 8'h00;
      forever begin
         @(negedge clk);
         if (tapLoad) begin
            lane_tap = tapOut;
            n_loads++;
         end
         if (bitslip) begin
            lane_slips++;
            n_slips++;
         end
         toggle = ~toggle;
         if (pass_mask[lane_tap]) din = (lane_slips >= need_slips) ? 8'hF0 : 8'hA5;
         else                     din = toggle ? 8'h55 : 8'hAA;
      end
   end

   // Expected outcome: {aligned, error, eyeWidth, eyeCenter, tapOut, slips, loads}
   function automatic logic [kExpW-1:0] expect_result(input logic [31:0] mask, input int need);
      int run_len, best_len, best_start, center, tap_f, slips, loads;
      logic al, er;
      run_len = 0; best_len = 0; best_start = 0;
      for (int t = 0; t <= 32; t++) begin
         if (t < 32 && mask[t[4:0]]) begin
            run_len++;
         end else begin
            if (run_len > best_len) begin
               best_len   = run_len;
               best_start = t - run_len;
            end
            run_len = 0;
         end
      end
      center = best_start + best_len / 2;
      if (best_len < kMinEye) begin
         al = 1'b0; er = 1'b1; tap_f = 31; slips = 0; loads = 32;
      end else if (need <= kMaxSlip) begin
         al = 1'b1; er = 1'b0; tap_f = center; slips = need; loads = 33;
      end else begin
         al = 1'b0; er = 1'b1; tap_f = center; slips = kMaxSlip; loads = 33;
      end
      return {al, er, 6'(best_len), 5'(center), 5'(tap_f), 4'(slips), 7'(loads)};
   endfunction

   // driver tasks
   task automatic arm_run(input logic [31:0] mask, input int need, input bit push);
      pass_mask  = mask;
      need_slips = need;
      lane_slips = 0;
      n_loads    = 0;
      n_slips    = 0;
      if (push) exp_q.push_back(expect_result(mask, need));
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_val("busy_after_start", 32'(busy), 32'd1);
      check_val("envtc_after_start", 32'(enVtc), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_tapOut"},    32'(tapOut),    32'd0);
      check_val({tag, "_tapLoad"},   32'(tapLoad),   32'd0);
      check_val({tag, "_enVtc"},     32'(enVtc),     32'd1);
      check_val({tag, "_bitslip"},   32'(bitslip),   32'd0);
      check_val({tag, "_busy"},      32'(busy),      32'd0);
      check_val({tag, "_aligned"},   32'(aligned),   32'd0);
      check_val({tag, "_error"},     32'(error),     32'd0);
      check_val({tag, "_eyeCenter"}, 32'(eyeCenter), 32'd0);
      check_val({tag, "_eyeWidth"},  32'(eyeWidth),  32'd0);
   endtask

   task automatic wait_done_and_score(input string tag);
      logic [kExpW-1:0] exp;
      int cyc;
      cyc = 0;
      while (busy && cyc < kBudget) begin
         @(negedge clk);
         cyc++;
      end
      if (busy) check_val({tag, "_done_timeout"}, 32'(busy), 32'd0);
      if (exp_q.size() == 0) begin
         check_val({tag, "_queue_empty"}, 32'd0, 32'd1);
      end else begin
         exp = exp_q.pop_front();
         check_val({tag, "_aligned"},   32'(aligned),   32'(exp[28]));
         check_val({tag, "_error"},     32'(error),     32'(exp[27]));
         check_val({tag, "_eyeWidth"},  32'(eyeWidth),  32'(exp[26:21]));
         check_val({tag, "_eyeCenter"}, 32'(eyeCenter), 32'(exp[20:16]));
         check_val({tag, "_tapOut"},    32'(tapOut),    32'(exp[15:11]));
         check_val({tag, "_slips"},     32'(n_slips),   32'(exp[10:7]));
         check_val({tag, "_loads"},     32'(n_loads),   32'(exp[6:0]));
         check_val({tag, "_busy"},      32'(busy),      32'd0);
         check_val({tag, "_enVtc"},     32'(enVtc),     32'd1);
      end
   endtask

   task automatic full_run(input string tag, input logic [31:0] mask, input int need);
      arm_run(mask, need, 1'b1);
      pulse_start();
      wait_done_and_score(tag);
   endtask

   // main sequence
   initial begin
      int cyc;
      rst = 1'b1; start = 1'b0; init_done = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // eye at 8..17, idle after 3 slips
      full_run("eye8_17", 32'h0003_FF00, 3);
      // two runs, the wider one wins
      full_run("two_runs", 32'h0FF0_003C, 0);
      // equal runs, the first one wins
      full_run("tie", 32'h00F0_003C, 0);
      // eye too narrow
      full_run("narrow", 32'h0000_0070, 0);
      // eye at the top edge, pattern never found
      full_run("no_idle", 32'hFF00_0000, 99);
      // random eye position, width 4..10, 0..8 slips
      begin
         int s, w;
         s = $urandom_range(0, 22);
         w = $urandom_range(4, 10);
         full_run("random", ((32'h1 << w) - 32'h1) << s, $urandom_range(0, kMaxSlip));
      end

      // reset during the tap-12 check window
      arm_run(32'h0003_FF00, 3, 1'b0);
      pulse_start();
      cyc = 0;
      while (!(tapLoad && tapOut == 5'd12) && cyc < kBudget) begin
         @(negedge clk);
         cyc++;
      end
      check_val("reach_tap12", 32'(tapOut), 32'd12);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("midrst");
      rst = 1'b0;
      @(negedge clk);

      // start held while IDELAY init is pending; init later drops mid-scan
      init_done = 1'b0;
      arm_run(32'h0003_FF00, 3, 1'b1);
      pulse_start();
      start = 1'b1;
      repeat (4) @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      check_val("no_load_before_init", 32'(n_loads), 32'd0);
      check_val("busy_wait_init", 32'(busy), 32'd1);
      init_done = 1'b1;
      cyc = 0;
      while (!(tapLoad && tapOut == 5'd3) && cyc < kBudget) begin
         @(negedge clk);
         cyc++;
      end
      init_done = 1'b0;
      wait_done_and_score("init_gate");
      init_done = 1'b1;

      // start re-pulsed while busy is ignored
      arm_run(32'h0003_FF00, 3, 1'b1);
      pulse_start();
      repeat (100) @(negedge clk);
      pulse_start();
      wait_done_and_score("restart_ignored");

      // start after a successful run clears aligned and rescans
      check_val("aligned_before_restart", 32'(aligned), 32'd1);
      arm_run(32'h0FF0_003C, 0, 1'b1);
      pulse_start();
      check_val("aligned_cleared", 32'(aligned), 32'd0);
      wait_done_and_score("rescan");

      check_val("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
